// File: rtl/bw_region_locator.sv
// bw_region_locator: per-frame bounding box and pixel count of dark pixels.
// Dark pixels count only when they belong to a horizontal run of at least
// MIN_RUN consecutive dark pixels in one row. This rejects isolated noise.
// Results are registered once per frame and flagged with a one-cycle o_done.
module bw_region_locator #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int MIN_RUN   = 4,
  parameter int MIN_COUNT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_bw,
  input  logic        i_valid,
  output logic [9:0]  o_x_min,
  output logic [9:0]  o_x_max,
  output logic [8:0]  o_y_min,
  output logic [8:0]  o_y_max,
  output logic [18:0] o_count,
  output logic        o_found,
  output logic        o_done,
  output logic        o_busy
);

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 19;
  localparam int RW = 4;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [RW-1:0] RUN_FULL = RW'(MIN_RUN);
  localparam logic [RW-1:0] RUN_PRE  = RW'(MIN_RUN - 1);
  localparam logic [XW-1:0] RUN_BACK = XW'(MIN_RUN - 1);
  localparam logic [CW-1:0] RUN_CNT  = CW'(MIN_RUN);
  localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [RW-1:0] run_q, run_d;
  logic [CW-1:0] count_q, count_d;
  logic [XW-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic          hit_q, hit_d;

  logic [XW-1:0] o_x_min_q, o_x_min_d, o_x_max_q, o_x_max_d;
  logic [YW-1:0] o_y_min_q, o_y_min_d, o_y_max_q, o_y_max_d;
  logic [CW-1:0] o_count_q, o_count_d;
  logic          o_found_q, o_found_d;
  logic          o_done_q, o_done_d;

  // Left edge of a run that has just reached MIN_RUN at column x_q.
  logic [XW-1:0] run_start;
  assign run_start = x_q - RUN_BACK;

  // Next-state, scan accumulation and result capture.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    run_d     = run_q;
    count_d   = count_q;
    x_min_d   = x_min_q;
    x_max_d   = x_max_q;
    y_min_d   = y_min_q;
    y_max_d   = y_max_q;
    hit_d     = hit_q;
    o_x_min_d = o_x_min_q;
    o_x_max_d = o_x_max_q;
    o_y_min_d = o_y_min_q;
    o_y_max_d = o_y_max_q;
    o_count_d = o_count_q;
    o_found_d = o_found_q;
    o_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SCAN;
          x_d     = '0;
          y_d     = '0;
          run_d   = '0;
          count_d = '0;
          x_min_d = '1;
          x_max_d = '0;
          y_min_d = '1;
          y_max_d = '0;
          hit_d   = 1'b0;
        end
      end

      S_SCAN: begin
        if (i_valid) begin
          // Run filter: the pixel that completes a run back-fills the whole run.
          if (!i_bw) begin
            run_d = '0;
          end else if (run_q == RUN_PRE) begin
            run_d   = RUN_FULL;
            count_d = count_q + RUN_CNT;
            if (run_start < x_min_q) x_min_d = run_start;
            if (x_q > x_max_q)       x_max_d = x_q;
            if (y_q < y_min_q)       y_min_d = y_q;
            if (y_q > y_max_q)       y_max_d = y_q;
            hit_d = 1'b1;
          end else if (run_q == RUN_FULL) begin
            count_d = count_q + CW'(1);
            if (x_q > x_max_q) x_max_d = x_q;
            if (y_q > y_max_q) y_max_d = y_q;
          end else begin
            run_d = run_q + RW'(1);
          end

          // Raster advance; a run never carries into the next row.
          if (x_q == X_LAST) begin
            x_d   = '0;
            y_d   = y_q + YW'(1);
            run_d = '0;
            if (y_q == Y_LAST) state_d = S_DONE;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end

      S_DONE: begin
        o_count_d = count_q;
        o_found_d = (count_q >= CNT_MIN);
        o_x_min_d = hit_q ? x_min_q : '0;
        o_x_max_d = hit_q ? x_max_q : '0;
        o_y_min_d = hit_q ? y_min_q : '0;
        o_y_max_d = hit_q ? y_max_q : '0;
        o_done_d  = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // A held start must not launch another frame.
        if (!i_start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      run_q     <= '0;
      count_q   <= '0;
      x_min_q   <= '0;
      x_max_q   <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
      hit_q     <= 1'b0;
      o_x_min_q <= '0;
      o_x_max_q <= '0;
      o_y_min_q <= '0;
      o_y_max_q <= '0;
      o_count_q <= '0;
      o_found_q <= 1'b0;
      o_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      run_q     <= run_d;
      count_q   <= count_d;
      x_min_q   <= x_min_d;
      x_max_q   <= x_max_d;
      y_min_q   <= y_min_d;
      y_max_q   <= y_max_d;
      hit_q     <= hit_d;
      o_x_min_q <= o_x_min_d;
      o_x_max_q <= o_x_max_d;
      o_y_min_q <= o_y_min_d;
      o_y_max_q <= o_y_max_d;
      o_count_q <= o_count_d;
      o_found_q <= o_found_d;
      o_done_q  <= o_done_d;
    end
  end

  assign o_x_min = o_x_min_q;
  assign o_x_max = o_x_max_q;
  assign o_y_min = o_y_min_q;
  assign o_y_max = o_y_max_q;
  assign o_count = o_count_q;
  assign o_found = o_found_q;
  assign o_done  = o_done_q;
  assign o_busy  = (state_q == S_SCAN);

endmodule

// File: tb/tb_bw_region_locator.sv
// Bench for bw_region_locator on a reduced frame size. Each frame image is
// built in an array; the expected result comes from scanning that image for
// maximal dark runs of length >= MR.
module tb_bw_region_locator;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int MR = 4;
  localparam int MC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_bw = 1'b0;
  logic        i_valid = 1'b0;
  logic [9:0]  o_x_min, o_x_max;
  logic [8:0]  o_y_min, o_y_max;
  logic [18:0] o_count;
  logic        o_found, o_done, o_busy;

  bw_region_locator #(.WIDTH(W), .HEIGHT(H), .MIN_RUN(MR), .MIN_COUNT(MC)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_bw(i_bw), .i_valid(i_valid),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_count(o_count), .o_found(o_found), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit img [0:H-1][0:W-1];
  int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_found;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic put_run(input int y, input int x0, input int len);
    for (int x = x0; x < x0 + len; x++) img[y][x] = 1'b1;
  endtask

  // Reference: every maximal dark run of length >= MR contributes all its pixels.
  task automatic model();
    bit hit = 0;
    e_cnt = 0; e_xmin = W; e_xmax = 0; e_ymin = H; e_ymax = 0;
    for (int y = 0; y < H; y++) begin
      int run = 0;
      for (int x = 0; x <= W; x++) begin
        bit dark = 1'b0;
        if (x < W) dark = img[y][x];
        if (dark) run++;
        else begin
          if (run >= MR) begin
            e_cnt += run;
            if (x - run < e_xmin) e_xmin = x - run;
            if (x - 1 > e_xmax)   e_xmax = x - 1;
            if (y < e_ymin)       e_ymin = y;
            if (y > e_ymax)       e_ymax = y;
            hit = 1;
          end
          run = 0;
        end
      end
    end
    if (!hit) begin e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; end
    e_found = (e_cnt >= MC) ? 1 : 0;
  endtask

  task automatic check_result(input string name);
    chk({name, ".count"}, o_count, e_cnt);
    chk({name, ".found"}, o_found, e_found);
    chk({name, ".x_min"}, o_x_min, e_xmin);
    chk({name, ".x_max"}, o_x_max, e_xmax);
    chk({name, ".y_min"}, o_y_min, e_ymin);
    chk({name, ".y_max"}, o_y_max, e_ymax);
  endtask

  // Streams the image; valid duty in percent. With hold_start the start
  // level stays high through and after the frame.
  task automatic run_frame(input string name, input int duty, input bit hold_start);
    int early_done = 0;
    int extra_done = 0;
    model();
    i_start = 1'b1;
    tick();
    chk({name, ".busy_start"}, o_busy, 1);
    if (!hold_start) i_start = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        while (duty < 100 && $urandom_range(0, 99) >= duty) begin
          i_valid = 1'b0;
          i_bw = 1'($urandom);
          tick();
          if (o_done) early_done++;
        end
        i_valid = 1'b1;
        i_bw = img[y][x];
        tick();
        if (o_done) early_done++;
      end
    end
    i_valid = 1'b0;
    chk({name, ".early_done"}, early_done, 0);
    chk({name, ".done_n1"}, o_done, 0);
    tick();
    chk({name, ".done_n2"}, o_done, 1);
    check_result(name);
    tick();
    chk({name, ".done_pulse"}, o_done, 0);
    chk({name, ".busy_after"}, o_busy, 0);
    // Pixels offered outside a scan must be ignored; results must hold.
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'($urandom);
      i_bw = 1'b1;
      tick();
      if (o_done || o_busy) extra_done++;
    end
    i_valid = 1'b0;
    chk({name, ".no_retrigger"}, extra_done, 0);
    chk({name, ".hold_count"}, o_count, e_cnt);
    i_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset.count", o_count, 0);
    chk("reset.x_max", o_x_max, 0);
    chk("reset.busy", o_busy, 0);
    chk("reset.done", o_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // All-light frame
    clear_img();
    run_frame("light", 100, 0);

    // Solid block
    clear_img();
    for (int y = 5; y <= 14; y++) put_run(y, 10, 20);
    run_frame("block", 100, 0);
    chk("block.const_count", o_count, 200);
    chk("block.const_found", o_found, 1);

    // Reset mid-scan, then a fresh frame
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      i_valid = 1'b1; i_bw = 1'b1; tick();
    end
    i_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_mid.count", o_count, 0);
    chk("rst_mid.x_max", o_x_max, 0);
    chk("rst_mid.y_max", o_y_max, 0);
    chk("rst_mid.found", o_found, 0);
    chk("rst_mid.busy", o_busy, 0);
    tick();
    rst = 1'b0;
    tick();
    run_frame("after_rst", 100, 0);

    // Noise rejection: isolated length-3 runs, one qualifying run
    clear_img();
    for (int y = 0; y < H; y++)
      if (y != 7)
        for (int c = 0; c + 3 <= W; c += 5)
          if ($urandom_range(0, 2) == 0) put_run(y, c, 3);
    put_run(7, 10, 4);
    run_frame("noise", 100, 0);
    chk("noise.const_count", o_count, 4);
    chk("noise.const_box", {o_x_min, o_x_max, o_y_min, o_y_max}, {10'd10, 10'd13, 9'd7, 9'd7});

    // Dark pixels spanning a row boundary never form a run
    clear_img();
    put_run(0, W - 2, 2);
    put_run(1, 0, 2);
    run_frame("wrap", 100, 0);

    // Random run patterns with random valid gaps
    for (int f = 0; f < 3; f++) begin
      clear_img();
      for (int y = 0; y < H; y++) begin
        int pos = $urandom_range(0, 8);
        while (pos < W) begin
          int len = $urandom_range(1, 7);
          if (pos + len > W) len = W - pos;
          if ($urandom_range(0, 3) != 0) put_run(y, pos, len);
          pos += len + $urandom_range(1, 10);
        end
      end
      run_frame($sformatf("rand%0d", f), 70, 0);
    end

    // Solid block, 50% valid duty, start held throughout
    clear_img();
    for (int y = 5; y <= 14; y++) put_run(y, 10, 20);
    run_frame("gapped", 50, 1);
    run_frame("restart", 100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bw_region_locator.md
Name: bw_region_locator

Overview:
- Consumes the binarised pixel stream (bw flag plus valid strobe) from the grayscale stage, one 640x480 frame per start.
- Tracks the bounding box and pixel count of dark (bw=1) pixels, rejecting isolated noise with a minimum horizontal run length.
- Reports the box once per frame, with a done pulse, for the overlay/control logic downstream.

Parameters:
- WIDTH, 640, pixels per row
- HEIGHT, 480, rows per frame
- MIN_RUN, 4, minimum consecutive dark pixels in a row for them to count (range 1..15)
- MIN_COUNT, 64, minimum qualifying pixels for o_found=1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  level frame-start request, same signal that drives the grayscale stage
- i_bw  in  1  pixel is dark (1) / light (0)
- i_valid  in  1  i_bw valid this cycle
- o_x_min  out  10  leftmost qualifying column
- o_x_max  out  10  rightmost qualifying column
- o_y_min  out  9  topmost qualifying row
- o_y_max  out  9  bottom qualifying row
- o_count  out  19  number of qualifying pixels
- o_found  out  1  o_count >= MIN_COUNT
- o_done  out  1  one-cycle pulse when outputs update
- o_busy  out  1  high in S_SCAN

Behaviour:
- Decided: one clock i_clk; reset i_rst is asynchronous, active-high. Reset clears state to S_IDLE and all counters and outputs to 0, with no partial result emitted.
- States: S_IDLE, S_SCAN, S_DONE, S_WAIT.
  - S_IDLE: i_start=1 -> S_SCAN. Clear x=0, y=0, run=0, count=0, min regs to all-ones, max regs to 0, and the internal hit flag.
  - S_SCAN: each cycle with i_valid=1 processes the pixel at (x,y). Cycles with i_valid=0 change nothing.
  - x increments. At x=WIDTH-1, x wraps to 0, y increments and run clears.
  - Pixel (WIDTH-1,HEIGHT-1) accepted -> S_DONE.
  - i_valid outside S_SCAN is ignored.
- Run filter (per accepted pixel):
  - i_bw=0: run=0.
  - i_bw=1: run saturates at MIN_RUN.
  - When run transitions MIN_RUN-1 -> MIN_RUN at column x:
    - count += MIN_RUN
    - x_min = min(x_min, x-MIN_RUN+1)
    - x_max = max(x_max, x)
    - y_min = min(y_min, y), y_max = max(y_max, y)
    - set hit
  - Dark pixel with run already at MIN_RUN: count += 1, x_max = max(x_max, x), y_max = max(y_max, y).
  - Runs never span rows.
- S_DONE (one cycle): register outputs.
  - o_count = count.
  - o_found = (count >= MIN_COUNT).
  - Box regs = accumulators if hit, else all four 0.
  - o_done = 1 for exactly the next cycle. Then S_WAIT.
- S_WAIT: stay until i_start=0, then S_IDLE. This prevents a held start from retriggering.
- Latency: last pixel presented in cycle N -> o_done high and outputs valid in cycle N+2.
- Outputs hold their values until the next S_DONE. o_busy = (state == S_SCAN).
- Widths: count max 307200 fits in 19 bits, so no saturation is needed. x and y compare unsigned.
- i_start=0 mid-scan has no effect. A frame in progress completes only by pixel count.

Test Plan:
- Reset mid-scan: assert i_rst after 1000 pixels -> all outputs 0, o_busy=0; the next i_start begins a fresh frame.
- All-light frame: 307200 pixels with i_bw=0 -> o_done pulse at N+2, o_count=0, o_found=0, box=0.
- Solid block: i_bw=1 for x=100..199, y=50..149 -> x_min=100, x_max=199, y_min=50, y_max=149, o_count=10000, o_found=1.
- Noise rejection: isolated runs of length 3 scattered over the frame, plus one run x=10..13 at y=7 -> o_count=4, box (10,13,7,7), o_found=0.
- Row-wrap run: dark at x=638,639 of row 0 and x=0,1 of row 1 -> no qualification, o_count=0.
- Gapped i_valid with start held high: random valid duty 50% on the solid-block frame -> same result as the solid-block case; no second o_done until i_start drops and rises again.
